lcd_ctrl: RTL and testbench
===========================

// Module: lcd_ctrl
// PURPOSE
//  Consumer end of the LSU LCD register (0x7030). Turns each 32-bit LCD word the
//  CPU stores into an HD44780-style bus cycle: setup, EN pulse, hold, then a
//  command execution wait. Provides a power-on init delay and a 1-deep pending
//  buffer. Exposes busy/overflow status so the LSU can map them for software polling.
// PARAMETERS
//  INIT_CYC   750000  power-on wait after reset before the first bus cycle (15 ms @ 50 MHz)
//  SETUP_CYC  4       cycles data/RS/RW are stable before EN rises
//  EN_CYC     12      EN high width in cycles
//  HOLD_CYC   2       cycles data/RS/RW are held after EN falls
//  EXEC_CYC   2000    execution wait for normal commands/data (40 us)
//  CLEAR_CYC  80000   execution wait for clear/home (1.6 ms)
// PORTS
//  i_clk        in   1   clock
//  i_rst        in   1   synchronous reset, active-high
//  i_lcd_wr     in   1   one-cycle strobe: LSU stored a word to the LCD register
//  i_lcd_word   in   32  word: [31] ON, [9] RW, [8] RS, [7:0] data
//  o_lcd_data   out  8   LCD data bus
//  o_lcd_rs     out  1   register select
//  o_lcd_rw     out  1   read/write (driven from word; no bus readback)
//  o_lcd_en     out  1   enable strobe
//  o_lcd_on     out  1   display power/backlight
//  o_busy       out  1   1 in INIT or any non-IDLE state
//  o_overflow   out  1   sticky: a word was dropped
// BEHAVIOUR
//  - Clocking and reset: one clock. i_rst is synchronous and active-high.
//  - Reset (next edge, overrides everything, including mid-cycle):
//    o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_overflow=0,
//    o_busy=1. Pending buffer is cleared. State goes to INIT with the counter loaded to INIT_CYC.
//  - FSM: INIT -> IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> (IDLE | SETUP).
//    INIT:  counts INIT_CYC cycles, then IDLE.
//    IDLE:  on i_lcd_wr, the word is issued; SETUP is entered on the next edge.
//           Otherwise, if the pending buffer is valid, its word is issued.
//    Issue: latches data/RS/RW/ON onto the outputs on the edge that enters SETUP.
//    SETUP: SETUP_CYC cycles, then PULSE.
//    PULSE: o_lcd_en=1 for exactly EN_CYC cycles, then HOLD.
//    HOLD:  HOLD_CYC cycles, then WAIT.
//    WAIT:  CLEAR_CYC cycles if RS=0 and data[7:2]==0 and data!=0; otherwise EXEC_CYC.
//           At the end of WAIT: go to SETUP with the pending word if it is valid (pending is
//           cleared), else go to IDLE.
//  - Latency: from an IDLE accept edge, EN rises SETUP_CYC cycles later. o_busy is
//    low again SETUP+EN+HOLD+WAIT+1 cycles after the accept edge.
//  - Pending buffer: a write in any non-IDLE state (INIT included) fills the empty
//    pending buffer. A write when pending is full drops the word and sets o_overflow.
//    If a write lands on the same edge the pending word is consumed, the new word
//    fills pending and no overflow is flagged.
//  - Data/RS/RW/ON outputs keep their last issued value in IDLE.
//  - The counter is a single down-counter of width $clog2(max param + 1). It is
//    reloaded on every state entry. A parameter value of 0 is treated as 1.
// STRUCTURE
//  - lcd_pkg: state enum (INIT, IDLE, SETUP, PULSE, HOLD, WAIT), word field bit
//    positions (LCD_ON_BIT=31, LCD_RW_BIT=9, LCD_RS_BIT=8), default timing constants.
//  - Sub-module lcd_timer: loadable down-counter with load value, load, and done outputs.
//  - Top level: FSM, output registers, pending register, overflow flag.
// TESTING (bench params: INIT=20, SETUP=2, EN=3, HOLD=1, EXEC=10, CLEAR=40)
//  1. Release reset -> all LCD outputs 0; o_busy=1 for 20 cycles, then 0.
//  2. Write 0x8000_0141 in IDLE -> next cycle data=0x41, RS=1, ON=1. EN is high
//     cycles 3-5 after accept. o_busy=0 at cycle 17.
//  3. Write 0x0000_0001 (clear) -> WAIT lasts 40 cycles; o_busy=0 at cycle 47.
//  4. Write 0x141, then 0x142 two cycles later -> two EN pulses. The second SETUP
//     starts right after the first WAIT, with no IDLE cycle between. o_overflow=0.
//  5. Write 0x141, 0x142, 0x143 on consecutive cycles -> the bus shows only 0x41
//     and 0x42. o_overflow=1 and stays set until reset.
//  6. Assert i_rst for 1 cycle during PULSE with pending full -> next edge
//     EN=0, data=0, pending empty, o_overflow=0. INIT restarts (busy=1 for 20 cycles).

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-style LCD bus controller.
//   - lcd_state_t : controller FSM states
//   - LCD_*_BIT   : field positions inside the 32-bit LCD register word
//   - DEF_*_CYC   : default timing in clock cycles (50 MHz clock)
//   - lcd_cmd_t   : the subset of the word that actually drives the bus
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_t;

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_RW_BIT = 9;
  localparam int LCD_RS_BIT = 8;

  localparam int DEF_INIT_CYC  = 750000;
  localparam int DEF_SETUP_CYC = 4;
  localparam int DEF_EN_CYC    = 12;
  localparam int DEF_HOLD_CYC  = 2;
  localparam int DEF_EXEC_CYC  = 2000;
  localparam int DEF_CLEAR_CYC = 80000;

  typedef struct packed {
    logic       on;
    logic       rw;
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  function automatic lcd_cmd_t word_to_cmd(input logic [31:0] w);
    lcd_cmd_t c;
    c.on   = w[LCD_ON_BIT];
    c.rw   = w[LCD_RW_BIT];
    c.rs   = w[LCD_RS_BIT];
    c.data = w[7:0];
    return c;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter used to time every controller state.
// A state loaded with N lasts exactly N cycles: o_done is high while the
// count is 1, which is the last cycle of the state.
// Ports:
//   i_clk      clock
//   i_load     load i_load_val this edge (takes priority over counting)
//   i_load_val cycle count for the state being entered
//   o_done     last cycle of the current count
module lcd_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      cnt <= i_load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign o_done = (cnt == CNT_W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns each 32-bit word the CPU stores to the LCD register into an
// HD44780-style bus cycle (setup, EN pulse, hold, execution wait), with a
// power-on delay and a single-entry pending buffer.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_lcd_wr            one-cycle store strobe
//   i_lcd_word          [31] ON, [9] RW, [8] RS, [7:0] data
//   o_lcd_data/rs/rw/en LCD bus
//   o_lcd_on            display power/backlight
//   o_busy              high in INIT and any non-IDLE state
//   o_overflow          sticky: a word was dropped because pending was full
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int INIT_CYC  = DEF_INIT_CYC,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EN_CYC    = DEF_EN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int EXEC_CYC  = DEF_EXEC_CYC,
  parameter int CLEAR_CYC = DEF_CLEAR_CYC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lcd_wr,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overflow
);

  localparam int MAX_CYC = max_int(max_int(max_int(INIT_CYC, SETUP_CYC),
                                           max_int(EN_CYC, HOLD_CYC)),
                                   max_int(max_int(EXEC_CYC, CLEAR_CYC), 1));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // A zero-length state would never see o_done, so it is stretched to 1.
  function automatic logic [CNT_W-1:0] cyc(input int n);
    return (n < 1) ? CNT_W'(1) : CNT_W'(n);
  endfunction

  lcd_state_t       state, nxt;
  lcd_cmd_t         pend_cmd, issue_cmd;
  logic             pend_vld;
  logic             take_wr, consume_pend, issue, pend_fill, is_clear;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;

  // Word bits outside ON/RW/RS/data are reserved and ignored.
  logic unused_word_bits;
  assign unused_word_bits = ^i_lcd_word[30:10];

  always_comb begin
    take_wr      = (state == ST_IDLE) && i_lcd_wr;
    // Pending is drained either from IDLE (no fresh write competing) or
    // directly at the end of WAIT, skipping IDLE entirely.
    consume_pend = pend_vld && (((state == ST_IDLE) && !i_lcd_wr) ||
                                ((state == ST_WAIT) && tmr_done));
    issue        = take_wr || consume_pend;
    issue_cmd    = take_wr ? word_to_cmd(i_lcd_word) : pend_cmd;
    // A write outside IDLE fills pending if it is empty or being emptied now.
    pend_fill    = i_lcd_wr && (state != ST_IDLE) && (!pend_vld || consume_pend);
    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    is_clear     = !o_lcd_rs && (o_lcd_data[7:2] == 6'd0) && (o_lcd_data != 8'd0);

    nxt = state;
    if (i_rst) begin
      nxt = ST_INIT;
    end else begin
      case (state)
        ST_INIT:  if (tmr_done) nxt = ST_IDLE;
        ST_IDLE:  if (issue)    nxt = ST_SETUP;
        ST_SETUP: if (tmr_done) nxt = ST_PULSE;
        ST_PULSE: if (tmr_done) nxt = ST_HOLD;
        ST_HOLD:  if (tmr_done) nxt = ST_WAIT;
        ST_WAIT:  if (tmr_done) nxt = pend_vld ? ST_SETUP : ST_IDLE;
        default:                nxt = ST_INIT;
      endcase
    end

    // No state ever transitions to itself, so a state change marks entry.
    tmr_load = i_rst || (nxt != state);
    case (nxt)
      ST_INIT:  tmr_val = cyc(INIT_CYC);
      ST_PULSE: tmr_val = cyc(EN_CYC);
      ST_HOLD:  tmr_val = cyc(HOLD_CYC);
      ST_WAIT:  tmr_val = is_clear ? cyc(CLEAR_CYC) : cyc(EXEC_CYC);
      default:  tmr_val = cyc(SETUP_CYC);
    endcase
  end

  lcd_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_done     (tmr_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_INIT;
      o_lcd_data <= 8'd0;
      o_lcd_rs   <= 1'b0;
      o_lcd_rw   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_on   <= 1'b0;
      o_busy     <= 1'b1;
      o_overflow <= 1'b0;
      pend_vld   <= 1'b0;
    end else begin
      state    <= nxt;
      o_lcd_en <= (nxt == ST_PULSE);
      o_busy   <= (nxt != ST_IDLE);
      if (issue) begin
        {o_lcd_on, o_lcd_rw, o_lcd_rs, o_lcd_data} <= issue_cmd;
      end
      if (i_lcd_wr && (state != ST_IDLE)) begin
        if (pend_fill) pend_vld   <= 1'b1;
        else           o_overflow <= 1'b1;
      end else if (consume_pend) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Pending payload is qualified by pend_vld, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (pend_fill) begin
      pend_cmd <= word_to_cmd(i_lcd_word);
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: self-checking bench for lcd_ctrl with short timing parameters.
// Expected bus words are queued as writes are driven and compared when EN rises.
module tb_lcd_ctrl;

  localparam int P_INIT  = 20;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 1;
  localparam int P_EXEC  = 10;
  localparam int P_CLEAR = 40;
  localparam int SEQ     = P_SETUP + P_EN + P_HOLD + P_EXEC;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [31:0] word;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, overflow;

  lcd_ctrl #(
    .INIT_CYC  (P_INIT),
    .SETUP_CYC (P_SETUP),
    .EN_CYC    (P_EN),
    .HOLD_CYC  (P_HOLD),
    .EXEC_CYC  (P_EXEC),
    .CLEAR_CYC (P_CLEAR)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_lcd_wr   (wr),
    .i_lcd_word (word),
    .o_lcd_data (lcd_data),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_en   (lcd_en),
    .o_lcd_on   (lcd_on),
    .o_busy     (busy),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [10:0] exp_q[$];
  int          n_pulse = 0;
  int          en_run  = 0;
  bit          abort_pulse = 1'b0;
  logic        prev_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus monitor: compare the latched word at each EN rise, width at each fall.
  always @(negedge clk) begin
    if (lcd_en && !prev_en) begin
      n_pulse++;
      en_run = 0;
      check("pulse_has_expect", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("bus_word", {21'd0, lcd_on, lcd_rw, lcd_rs, lcd_data}, {21'd0, exp_q.pop_front()});
    end
    if (lcd_en) en_run++;
    if (!lcd_en && prev_en) begin
      if (!abort_pulse) check("en_width", en_run, P_EN);
      abort_pulse = 1'b0;
    end
    prev_en = lcd_en;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one write for one cycle starting at a negedge; returns on the next negedge.
  task automatic lcd_write(input logic [31:0] w, input bit expect_issue);
    wr   = 1'b1;
    word = w;
    if (expect_issue) exp_q.push_back({w[31], w[9], w[8], w[7:0]});
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Steps negedge by negedge (cycle index k) until busy drops, bounded.
  task automatic run_until_idle(input int start_k, output int busy_low,
                                output int en_first, output int en_last, output int rises);
    int   k;
    logic pe;
    k = start_k; pe = 1'b0;
    busy_low = -1; en_first = -1; en_last = -1; rises = 0;
    while (k < start_k + 300) begin
      if (lcd_en) begin
        if (!pe) rises++;
        if (en_first < 0) en_first = k;
        en_last = k;
      end
      pe = lcd_en;
      if (!busy) begin
        busy_low = k;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int n, bl, ef, el, r, pulses_before;
    rst = 1'b1; wr = 1'b0; word = 32'd0;
    repeat (3) @(negedge clk);

    // 1: reset state and power-on delay
    check("rst_data", lcd_data, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_en", lcd_en, 0);
    check("rst_on", lcd_on, 0);
    check("rst_busy", busy, 1);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    count_busy(n);
    check("init_busy_cycles", n, P_INIT);

    // 2: single data write
    lcd_write(32'h8000_0141, 1'b1);
    check("t2_data", lcd_data, 8'h41);
    check("t2_rs", lcd_rs, 1);
    check("t2_rw", lcd_rw, 0);
    check("t2_on", lcd_on, 1);
    check("t2_busy", busy, 1);
    run_until_idle(1, bl, ef, el, r);
    check("t2_en_first", ef, P_SETUP + 1);
    check("t2_en_last", el, P_SETUP + P_EN);
    check("t2_busy_low", bl, SEQ + 1);
    @(negedge clk);
    check("t2_idle_hold_data", lcd_data, 8'h41);
    check("t2_idle_hold_on", lcd_on, 1);

    // 3: clear display uses the long wait
    lcd_write(32'h0000_0001, 1'b1);
    check("t3_data", lcd_data, 8'h01);
    check("t3_on", lcd_on, 0);
    run_until_idle(1, bl, ef, el, r);
    check("t3_busy_low", bl, P_SETUP + P_EN + P_HOLD + P_CLEAR + 1);
    check("t3_en_first", ef, P_SETUP + 1);

    // 4: second write queued in pending, back-to-back sequences
    lcd_write(32'h0000_0141, 1'b1);
    @(negedge clk);
    lcd_write(32'h0000_0142, 1'b1);
    run_until_idle(3, bl, ef, el, r);
    check("t4_busy_low", bl, 2 * SEQ + 1);
    check("t4_pulses", r, 2);
    check("t4_en_last", el, SEQ + P_SETUP + P_EN);
    check("t4_ovf", overflow, 0);
    check("t4_data", lcd_data, 8'h42);

    // 5: third write on consecutive cycles overflows
    lcd_write(32'h0000_0141, 1'b1);
    lcd_write(32'h0000_0142, 1'b1);
    lcd_write(32'h0000_0143, 1'b0);
    check("t5_ovf_set", overflow, 1);
    run_until_idle(3, bl, ef, el, r);
    check("t5_busy_low", bl, 2 * SEQ + 1);
    check("t5_pulses", r, 2);
    check("t5_data", lcd_data, 8'h42);
    check("t5_ovf_sticky", overflow, 1);

    // 6: reset mid-pulse with pending full
    lcd_write(32'h0000_0141, 1'b1);
    lcd_write(32'h0000_0142, 1'b1);
    @(negedge clk);
    check("t6_in_pulse", lcd_en, 1);
    check("t6_ovf_before", overflow, 1);
    rst = 1'b1;
    abort_pulse = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("t6_en", lcd_en, 0);
    check("t6_data", lcd_data, 0);
    check("t6_rs", lcd_rs, 0);
    check("t6_on", lcd_on, 0);
    check("t6_ovf", overflow, 0);
    pulses_before = n_pulse;
    count_busy(n);
    check("t6_init_busy_cycles", n, P_INIT);
    repeat (40) @(negedge clk);
    check("t6_no_stale_pulse", n_pulse, pulses_before);
    check("t6_idle_busy", busy, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
